// File: rtl/data_mem_responder.sv
// data_mem_responder: load/store responder for the core datapath.
// Word-organised RAM with byte/halfword/word access, WAIT_CYCLES wait states
// and a busy stall toward the core. RAM is written and read on the edge that
// enters DONE; the load result is registered.
// Optional: define MISALIGN_TRAP_EN to flag misaligned halfword/word accesses
// (no write, rdata = 0, o_misalign high in the DONE cycle).
//
// state    | meaning
// S_IDLE   | waiting for i_req_valid; request latched on acceptance
// S_ACCESS | wait states counting down
// S_DONE   | response cycle: o_rsp_valid = 1, o_busy = 0
module data_mem_responder #(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_req_valid,
  input  logic        i_req_we,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_rsp_valid,
  output logic [31:0] o_rdata,
  output logic        o_misalign
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_DONE   = 2'd2;
  localparam logic [3:0] WAIT_LD  = 4'(WAIT_CYCLES);

  logic [1:0]  r_state;
  logic [3:0]  r_cnt;
  logic        r_we;
  logic [2:0]  r_funct3;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [31:0] r_rdata;
  logic        r_misalign;
  logic [31:0] r_mem [DEPTH_WORDS];

  logic        w_take;
  logic        w_enter_done;
  logic        w_src_we;
  logic [2:0]  w_src_f3;
  logic [31:0] w_src_addr;
  logic [31:0] w_src_wdata;
  logic [AW-1:0] w_idx;
  logic [1:0]  w_off;
  logic        w_is_half;
  logic        w_is_word;
  logic        w_mis;
  logic [3:0]  w_be;
  logic [31:0] w_wlane;
  logic        w_wr_en;
  logic [31:0] w_word;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load;
  logic [31:0] w_rsp_data;
  logic        w_unused;

  // With zero wait states the DONE-entry edge is the acceptance edge, so the
  // access must use the live inputs there; otherwise the latched request.
  always_comb begin
    w_take       = (r_state == S_IDLE) && i_req_valid;
    w_src_we     = (r_state == S_IDLE) ? i_req_we : r_we;
    w_src_f3     = (r_state == S_IDLE) ? i_funct3 : r_funct3;
    w_src_addr   = (r_state == S_IDLE) ? i_addr   : r_addr;
    w_src_wdata  = (r_state == S_IDLE) ? i_wdata  : r_wdata;
    w_enter_done = (w_take && (WAIT_CYCLES == 0)) ||
                   ((r_state == S_ACCESS) && (r_cnt == 4'd1));
    w_idx        = w_src_addr[AW+1:2];
    w_off        = w_src_addr[1:0];
    w_is_half    = (w_src_f3 == 3'b001) || (!w_src_we && (w_src_f3 == 3'b101));
    w_is_word    = (w_src_f3 == 3'b010);
`ifdef MISALIGN_TRAP_EN
    w_mis        = (w_is_half && w_off[0]) || (w_is_word && (w_off != 2'b00));
`else
    w_mis        = 1'b0;
`endif
    w_unused     = ^{w_src_addr[31:AW+2], w_is_half, w_is_word};
  end

  // Store lane selection: byte enables and the store data replicated per lane.
  always_comb begin
    w_be    = 4'b0000;
    w_wlane = {4{w_src_wdata[7:0]}};
    case (w_src_f3)
      3'b000: w_be = 4'b0001 << w_off;
      3'b001: begin
        w_be    = w_off[1] ? 4'b1100 : 4'b0011;
        w_wlane = {2{w_src_wdata[15:0]}};
      end
      3'b010: begin
        w_be    = 4'b1111;
        w_wlane = w_src_wdata;
      end
      default: w_be = 4'b0000;
    endcase
    w_wr_en = w_enter_done && !i_reset && w_src_we && !w_mis;
  end

  // Load formatting from the addressed word.
  always_comb begin
    w_word = r_mem[w_idx];
    w_byte = w_word[{w_off, 3'b000} +: 8];
    w_half = w_off[1] ? w_word[31:16] : w_word[15:0];
    case (w_src_f3)
      3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
      3'b001:  w_load = {{16{w_half[15]}}, w_half};
      3'b010:  w_load = w_word;
      3'b100:  w_load = {24'd0, w_byte};
      3'b101:  w_load = {16'd0, w_half};
      default: w_load = 32'd0;
    endcase
    w_rsp_data = (w_src_we || w_mis) ? 32'd0 : w_load;
  end

  // RAM write with per-lane enables; contents are never reset.
  always_ff @(posedge i_clk) begin
    if (w_wr_en) begin
      for (int k = 0; k < 4; k++) begin
        if (w_be[k]) r_mem[w_idx][8*k +: 8] <= w_wlane[8*k +: 8];
      end
    end
  end

  // Control FSM, request latch, registered response.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state    <= S_IDLE;
      r_cnt      <= 4'd0;
      r_we       <= 1'b0;
      r_funct3   <= 3'd0;
      r_addr     <= 32'd0;
      r_wdata    <= 32'd0;
      r_rdata    <= 32'd0;
      r_misalign <= 1'b0;
    end else begin
      r_misalign <= w_enter_done ? w_mis : 1'b0;
      if (w_enter_done) r_rdata <= w_rsp_data;
      case (r_state)
        S_IDLE: begin
          if (i_req_valid) begin
            r_we     <= i_req_we;
            r_funct3 <= i_funct3;
            r_addr   <= i_addr;
            r_wdata  <= i_wdata;
            r_cnt    <= WAIT_LD;
            r_state  <= (WAIT_CYCLES == 0) ? S_DONE : S_ACCESS;
          end
        end
        S_ACCESS: begin
          if (r_cnt == 4'd1) r_state <= S_DONE;
          else               r_cnt   <= r_cnt - 4'd1;
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_busy      = ((r_state != S_IDLE) && (r_state != S_DONE)) ||
                       ((r_state == S_IDLE) && i_req_valid);
  assign o_rsp_valid = (r_state == S_DONE);
  assign o_rdata     = r_rdata;
  assign o_misalign  = r_misalign;

endmodule

// File: tb/tb_data_mem_responder.sv
// Testbench for data_mem_responder: byte-array reference model, directed
// cases plus randomized accesses.
module tb_data_mem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        rsp_valid;
  logic [31:0] rdata;
  logic        misalign;

  int n_cmp = 0;
  int n_mis = 0;
  logic [7:0] mdl [DEPTH*4];

  data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC)) dut (
    .i_clk(clk), .i_reset(reset), .i_req_valid(req_valid), .i_req_we(req_we),
    .i_funct3(funct3), .i_addr(addr), .i_wdata(wdata),
    .o_busy(busy), .o_rsp_valid(rsp_valid), .o_rdata(rdata), .o_misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_mis++;
      $display("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Little-endian value of nbytes model bytes starting at base.
  function automatic longint le_val(input int base, input int nbytes);
    longint v = 0;
    for (int i = 0; i < nbytes; i++) v = v + longint'(mdl[base+i]) * (longint'(1) << (8*i));
    return v;
  endfunction

  task automatic access(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd);
    int base, off, hb, cyc;
    bit is_half, is_word, mis, done;
    longint v;
    logic [31:0] exp_rd;
    base    = int'((a >> 2) % DEPTH) * 4;
    off     = int'(a % 4);
    hb      = base + (off / 2) * 2;
    is_half = (f3 == 3'd1) || (!we && f3 == 3'd5);
    is_word = (f3 == 3'd2);
    mis     = 1'b0;
`ifdef MISALIGN_TRAP_EN
    mis     = (is_half && (off % 2 == 1)) || (is_word && off != 0);
`endif
    exp_rd  = 32'd0;
    if (!mis) begin
      if (we) begin
        case (f3)
          3'd0: mdl[base+off] = wd[7:0];
          3'd1: begin mdl[hb] = wd[7:0]; mdl[hb+1] = wd[15:8]; end
          3'd2: for (int i = 0; i < 4; i++) mdl[base+i] = 8'((wd >> (8*i)) % 256);
          default: ;
        endcase
      end else begin
        case (f3)
          3'd0: begin v = le_val(base+off, 1); exp_rd = (v >= 128) ? 32'(v - 256) : 32'(v); end
          3'd1: begin v = le_val(hb, 2); exp_rd = (v >= 32768) ? 32'(v - 65536) : 32'(v); end
          3'd2: exp_rd = 32'(le_val(base, 4));
          3'd4: exp_rd = 32'(le_val(base+off, 1));
          3'd5: exp_rd = 32'(le_val(hb, 2));
          default: exp_rd = 32'd0;
        endcase
      end
    end
    @(negedge clk);
    req_valid = 1'b1; req_we = we; funct3 = f3; addr = a; wdata = wd;
    #1;
    chk("busy_on_req", {31'd0, busy}, 32'd1);
    chk("rsp_idle", {31'd0, rsp_valid}, 32'd0);
    @(posedge clk);
    cyc = 0; done = 1'b0;
    while (!done && cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rsp_valid) begin
        done = 1'b1;
        chk("latency", cyc, WAITC + 1);
        chk("busy_done", {31'd0, busy}, 32'd0);
        chk("rdata", rdata, exp_rd);
        chk("misalign", {31'd0, misalign}, {31'd0, mis});
        req_valid = 1'b0;
      end else begin
        chk("busy_wait", {31'd0, busy}, 32'd1);
        chk("misalign_wait", {31'd0, misalign}, 32'd0);
        req_valid = 1'($urandom_range(0, 1));
        req_we    = 1'($urandom_range(0, 1));
        funct3    = 3'($urandom);
        addr      = $urandom;
        wdata     = $urandom;
      end
    end
    if (!done) begin
      chk("rsp_timeout", 32'd0, 32'd1);
      req_valid = 1'b0;
    end
  endtask

  task automatic idle_check(input string tag, input int ncyc);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      chk(tag, {30'd0, busy, rsp_valid}, 32'd0);
    end
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_we = 1'b0; funct3 = 3'd0; addr = 32'd0; wdata = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_misalign", {31'd0, misalign}, 32'd0);
    chk("rst_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    for (int w = 0; w < DEPTH; w++) access(1'b1, 3'd2, 32'(w * 4), $urandom);

    access(1'b1, 3'd2, 32'h10, 32'hDEADBEEF);
    access(1'b0, 3'd2, 32'h10, 32'h0);
    access(1'b1, 3'd2, 32'h20, 32'h11223380);
    access(1'b0, 3'd0, 32'h20, 32'h0);
    access(1'b0, 3'd4, 32'h20, 32'h0);
    access(1'b0, 3'd1, 32'h22, 32'h0);
    access(1'b1, 3'd2, 32'h30, 32'hAABBCCDD);
    access(1'b1, 3'd0, 32'h31, 32'h00000055);
    access(1'b0, 3'd2, 32'h30, 32'h0);
    access(1'b1, 3'd1, 32'h32, 32'h00001234);
    access(1'b0, 3'd2, 32'h30, 32'h0);
    access(1'b1, 3'd2, 32'h1000, 32'hCAFEF00D);
    access(1'b0, 3'd2, 32'h0, 32'h0);
    access(1'b0, 3'd2, 32'h42, 32'h0);
    access(1'b1, 3'd1, 32'h41, 32'h0000BEEF);
    access(1'b0, 3'd2, 32'h40, 32'h0);

    // reset in cycle 1 of a store: aborted, RAM unchanged
    access(1'b1, 3'd2, 32'h40, 32'h01020304);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 32'h40; wdata = 32'h99999999;
    @(posedge clk);
    @(negedge clk);
    chk("abort_rsp_c1", {31'd0, rsp_valid}, 32'd0);
    reset = 1'b1; req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("abort_rdata", rdata, 32'd0);
    idle_check("abort_idle", WAITC + 3);
    access(1'b0, 3'd2, 32'h40, 32'h0);

    // reset and req_valid together: request is not accepted
    @(negedge clk);
    reset = 1'b1; req_valid = 1'b1; req_we = 1'b1; funct3 = 3'd2; addr = 32'h40; wdata = 32'h77777777;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0; req_valid = 1'b0;
    idle_check("rst_req_idle", WAITC + 3);
    access(1'b0, 3'd2, 32'h40, 32'h0);

    for (int i = 0; i < 400; i++) begin
      logic [31:0] ra;
      ra = (i % 2 == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      access(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), ra, $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Memory-side responder for the core datapath's load/store port.
- Accepts the datapath's address, store data and funct3; performs byte, halfword or word loads and stores against an internal word-organised RAM.
- Returns the load value for the register write-back mux.
- Models configurable wait states and stalls the single-cycle core with a busy handshake until the access completes.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the RAM; power of two.
- WAIT_CYCLES, 2, extra access cycles between request acceptance and completion; 0..15.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- req_valid  input  1  datapath requests a memory access this cycle.
- req_we  input  1  1 = store, 0 = load.
- funct3  input  3  RV32I access size/sign code.
- addr  input  32  byte address from the ALU result.
- wdata  input  32  store data, from the rs2 value.
- busy  output  1  stall to the core. Combinational: (state != IDLE && state != DONE) || (state == IDLE && req_valid).
- rsp_valid  output  1  high for exactly the DONE cycle.
- rdata  output  32  load result; feeds the datapath's memory data input.
- misalign  output  1  misaligned-access flag; see Optional Feature.

Behaviour:
- Reset: state = IDLE; rsp_valid = 0; rdata = 0; misalign = 0; latched request registers = 0. RAM contents are not reset.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - If req_valid = 1, latch req_we, funct3, addr and wdata, and load wait counter = WAIT_CYCLES.
  - Go to ACCESS if WAIT_CYCLES > 0, else go directly to DONE.
- ACCESS: decrement counter each cycle; when counter reaches 1, the next edge enters DONE.
- Latency: acceptance edge at cycle 0 → DONE during cycle WAIT_CYCLES+1.
- DONE:
  - rsp_valid = 1, busy = 0; rdata valid; the core commits this cycle.
  - Next state is always IDLE. A req_valid seen in DONE is ignored; the request is re-sampled in IDLE.
- Timing of RAM access: the store write and load read both happen on the edge entering DONE, using the latched request; rdata is registered.
- Word index: latched addr[log2(DEPTH_WORDS)+1 : 2]. Upper address bits are ignored, so addresses wrap modulo DEPTH_WORDS*4.
- Stores:
  - 000 SB: write byte lane addr[1:0] with wdata[7:0].
  - 001 SH: write halfword lane addr[1] with wdata[15:0].
  - 010 SW: write the full word.
  - Other funct3 values: no write.
  - rdata = 0 on store completion.
- Loads:
  - 000 LB: sign-extend the selected byte.
  - 001 LH: sign-extend the selected halfword.
  - 010 LW: full word.
  - 100 LBU: zero-extend the selected byte.
  - 101 LHU: zero-extend the selected halfword.
  - Other funct3 values: rdata = 0.
- Unselected bytes of the addressed word are never modified.
- Changes to request inputs while busy = 1 have no effect; only the latched values are used.
- Reset mid-operation: aborts the access. If the DONE-entry edge has not yet occurred, a pending store is discarded and the RAM is unchanged. Next state is IDLE.
- Reset and req_valid in the same cycle: reset wins; the request is not accepted.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - A halfword access with addr[0] = 1, or a word access with addr[1:0] != 0, performs no RAM write.
  - It returns rdata = 0 and drives misalign = 1 during the DONE cycle only.
  - Latency is unchanged.
- Undefined:
  - Low address bits are ignored: halfword uses addr[1] only; word ignores addr[1:0].
  - misalign is tied to 0.

Test Plan:
- Word store then load, WAIT_CYCLES=2: SW addr=0x10, wdata=0xDEADBEEF, then LW addr=0x10 → busy high for cycles 0..2 of each access, rsp_valid in cycle 3, rdata = 0xDEADBEEF.
- Byte/sign handling: SW 0x11223380 @0x20; LB @0x20 → 0xFFFFFF80; LBU @0x20 → 0x00000080; LH @0x22 → 0x00001122.
- Partial store: SW 0xAABBCCDD @0x30; SB wdata=0x55 @0x31; LW @0x30 → 0xAABB55DD. SH wdata=0x1234 @0x32; LW @0x30 → 0x123455DD.
- Wrap-around, DEPTH_WORDS=1024: SW 0xCAFEF00D @0x1000; LW @0x0 → 0xCAFEF00D.
- Reset mid-store: SW 0x99999999 @0x40 (word holds 0x01020304); assert reset in cycle 1 → state IDLE, rsp_valid never pulses, LW @0x40 → 0x01020304.
- MISALIGN_TRAP_EN defined: LW @0x42 → misalign = 1 and rdata = 0 in the DONE cycle. SH @0x41 → RAM unchanged. Undefined: LW @0x42 returns the word at 0x40 and misalign = 0.
